// File: rtl/note_duration_timer_pkg.sv
// audio_pkg: note-length codes, durations in twelfths of a beat, and channel state type
package audio_pkg;
  localparam logic [3:0] SEMIQUAVER = 4'd1, TUPLET = 4'd2, QUAVER = 4'd3, DOTTED_QUAVER = 4'd4,
    CROTCHET = 4'd5, DOTTED_CROTCHET = 4'd6, MINIM = 4'd7, DOTTED_MINIM = 4'd8,
    SEMIBREVE = 4'd9, BREVE = 4'd10;
  localparam logic [6:0] TW_UNDEF = 7'd2, TW_SEMIQUAVER = 7'd3, TW_TUPLET = 7'd4, TW_QUAVER = 7'd6,
    TW_DOTTED_QUAVER = 7'd9, TW_CROTCHET = 7'd12, TW_DOTTED_CROTCHET = 7'd18, TW_MINIM = 7'd24,
    TW_DOTTED_MINIM = 7'd36, TW_SEMIBREVE = 7'd48, TW_BREVE = 7'd96;
  typedef enum logic {IDLE, RUN} chan_state_e;
  function automatic logic [6:0] note_twelfths(input logic [3:0] code);
    case (code)
      SEMIQUAVER:      return TW_SEMIQUAVER;
      TUPLET:          return TW_TUPLET;
      QUAVER:          return TW_QUAVER;
      DOTTED_QUAVER:   return TW_DOTTED_QUAVER;
      CROTCHET:        return TW_CROTCHET;
      DOTTED_CROTCHET: return TW_DOTTED_CROTCHET;
      MINIM:           return TW_MINIM;
      DOTTED_MINIM:    return TW_DOTTED_MINIM;
      SEMIBREVE:       return TW_SEMIBREVE;
      BREVE:           return TW_BREVE;
      default:         return TW_UNDEF;
    endcase
  endfunction
endpackage

// File: rtl/note_duration_timer_channel.sv
// note_channel_timer: one channel's countdown, staccato gap and IDLE/RUN state
module note_channel_timer
  import audio_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             pause,
  input  logic             start,
  input  logic [WIDTH-1:0] dur,
  input  logic             staccato,
  output logic             busy,
  output logic             gate,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);
  chan_state_e state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, gap_q, gap_d;
  logic done_q, done_d, step, fin;
  assign step = tick && !pause && state_q == RUN;
  assign fin = step && rem_q == WIDTH'(1);
  // A start on the final tick still reports the old note's end, then reloads.
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    gap_d = gap_q;
    done_d = fin;
    if (start) begin
      state_d = RUN;
      rem_d = dur;
      gap_d = staccato ? dur >> 2 : '0;
    end else if (step) begin
      rem_d = rem_q - WIDTH'(1);
      state_d = fin ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      gap_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      gap_q <= gap_d;
      done_q <= done_d;
    end
  assign busy = state_q == RUN;
  assign gate = busy && rem_q > gap_q;
  assign done = done_q;
  assign remaining = rem_q;
endmodule

// File: rtl/note_duration_timer.sv
// note_duration_timer: multi-channel note-length decoder and countdown on the BPM prescaler tick
module note_duration_timer
  import audio_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 16,
  parameter int BEAT_TICKS = 6000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      pause,
  input  logic [CHANNELS-1:0]       start,
  input  logic [4*CHANNELS-1:0]     code,
  input  logic [CHANNELS-1:0]       staccato,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       gate,
  output logic [CHANNELS-1:0]       done,
  output logic [WIDTH*CHANNELS-1:0] remaining
);
  localparam logic [WIDTH-1:0] UNIT = WIDTH'(BEAT_TICKS / 12);
  if (BEAT_TICKS <= 0 || BEAT_TICKS % 12 != 0) begin : g_bad_beat
    $error("BEAT_TICKS must be a positive multiple of 12");
  end
  if (longint'(8) * longint'(BEAT_TICKS) >= (longint'(1) << WIDTH)) begin : g_bad_width
    $error("WIDTH cannot hold a breve of 8*BEAT_TICKS");
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] dur;
    assign dur = UNIT * WIDTH'(note_twelfths(code[4*c +: 4]));
    note_channel_timer #(.WIDTH(WIDTH)) u_ch (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .pause(pause),
      .start(start[c]),
      .dur(dur),
      .staccato(staccato[c]),
      .busy(busy[c]),
      .gate(gate[c]),
      .done(done[c]),
      .remaining(remaining[WIDTH*c +: WIDTH])
    );
  end
endmodule
